// File: rtl/bram_ring_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bram_ring_writer                                           |
// | Description : Streams source words into a BRAM ring buffer through a    |
// |               single write port, one registered write strobe per        |
// |               accepted word. Tracks the write pointer, counts completed |
// |               frames and flags a sticky overflow when the ring is full. |
// |               A stop request finishes the current frame before the      |
// |               block goes idle.                                           |
// | Ports       : porta_clk/porta_rst  clock, synchronous active-high reset |
// |               ctrl_enable/clear    software run level / status clear    |
// |               s_valid/s_data/s_ready  source handshake                  |
// |               rd_ptr               software read pointer (words)        |
// |               bram_en/we/addr/din  BRAM port-A write strobe            |
// |               wr_ptr/frame_count/overflow/busy  status                 |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module bram_ring_writer #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16384,
  parameter int FRAME_WORDS = 32,
  localparam int PW         = $clog2(DEPTH)
) (
  input  logic                  porta_clk,
  input  logic                  porta_rst,
  input  logic                  ctrl_enable,
  input  logic                  ctrl_clear,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  input  logic [PW-1:0]         rd_ptr,
  output logic                  bram_en,
  output logic [3:0]            bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  output logic [PW-1:0]         wr_ptr,
  output logic [31:0]           frame_count,
  output logic                  overflow,
  output logic                  busy
);

  // Frame counter width; a one-word frame still needs a 1-bit register.
  localparam int WIF_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [WIF_W-1:0] LAST_WORD = WIF_W'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [PW-1:0]           r_wr_ptr;
  logic [WIF_W-1:0]        r_word_in_frame;
  logic [31:0]             r_frame_count;
  logic                    r_overflow;
  logic                    r_bram_en;
  logic [3:0]              r_bram_we;
  logic [ADDR_WIDTH-1:0]   r_bram_addr;
  logic [DATA_WIDTH-1:0]   r_bram_din;

  logic [PW-1:0]           w_wr_ptr_inc;
  logic                    w_full;
  logic                    w_active;
  logic                    w_ready;
  logic                    w_xfer;
  logic                    w_frame_last;
  logic [WIF_W-1:0]        w_wif_nxt;
  logic                    w_clear;

  // Pointer arithmetic wraps naturally at PW bits because DEPTH is 2**PW.
  // Full compares against the live rd_ptr so a pointer update in the same
  // cycle as a transfer is honoured immediately; one slot stays unused.
  assign w_wr_ptr_inc = r_wr_ptr + PW'(1);
  assign w_full       = (w_wr_ptr_inc == rd_ptr);
  assign w_active     = (r_state != ST_IDLE);
  assign w_ready      = w_active && !w_full;
  assign w_xfer       = s_valid && w_ready;
  assign w_frame_last = (r_word_in_frame == LAST_WORD);
  assign w_wif_nxt    = w_frame_last ? '0 : (r_word_in_frame + WIF_W'(1));
  assign w_clear      = ctrl_clear && (r_state == ST_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (ctrl_enable) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // Stopping on a frame boundary goes straight to idle; otherwise the
        // partial frame is completed in DRAIN first.
        if (!ctrl_enable) begin
          w_state_nxt = (r_word_in_frame != '0) ? ST_DRAIN : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        // A renewed run request takes precedence over finishing the frame.
        if (ctrl_enable) begin
          w_state_nxt = ST_RUN;
        end else if (w_xfer && w_frame_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge porta_clk) begin
    if (porta_rst) begin
      r_state         <= ST_IDLE;
      r_wr_ptr        <= '0;
      r_word_in_frame <= '0;
      r_frame_count   <= '0;
      r_overflow      <= 1'b0;
      r_bram_en       <= 1'b0;
      r_bram_we       <= 4'h0;
      r_bram_addr     <= '0;
      r_bram_din      <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bram_en <= w_xfer;
      r_bram_we <= w_xfer ? 4'hF : 4'h0;

      // Address and data only move on a real write so the port holds its
      // last value between strobes.
      if (w_xfer) begin
        r_bram_addr <= ADDR_WIDTH'({r_wr_ptr, 2'b00});
        r_bram_din  <= s_data;
      end

      // Set requires a non-idle state and clear requires idle, so the two
      // never compete in the same cycle.
      if (w_active && s_valid && w_full) begin
        r_overflow <= 1'b1;
      end

      if (w_clear) begin
        r_wr_ptr        <= '0;
        r_word_in_frame <= '0;
        r_frame_count   <= '0;
        r_overflow      <= 1'b0;
      end else if (w_xfer) begin
        r_wr_ptr        <= w_wr_ptr_inc;
        r_word_in_frame <= w_wif_nxt;
        if (w_frame_last) begin
          r_frame_count <= r_frame_count + 32'd1;
        end
      end
    end
  end

  assign s_ready     = w_ready;
  assign bram_en     = r_bram_en;
  assign bram_we     = r_bram_we;
  assign bram_addr   = r_bram_addr;
  assign bram_din    = r_bram_din;
  assign wr_ptr      = r_wr_ptr;
  assign frame_count = r_frame_count;
  assign overflow    = r_overflow;
  assign busy        = w_active;

endmodule
`default_nettype wire

// File: tb/tb_bram_ring_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_bram_ring_writer                                        |
// | Description : Self-checking bench for bram_ring_writer. A word-count     |
// |               based reference model predicts handshakes, status and the |
// |               BRAM write stream; a monitor collects observed writes.    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_bram_ring_writer;

  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 16384;
  localparam int FW    = 32;
  localparam int PW    = 14;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;

  logic          clk = 1'b0;
  logic          porta_rst;
  logic          ctrl_enable;
  logic          ctrl_clear;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic [PW-1:0] rd_ptr;
  logic          bram_en;
  logic [3:0]    bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   frame_count;
  logic          overflow;
  logic          busy;

  bram_ring_writer #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .FRAME_WORDS(FW)
  ) dut (
    .porta_clk  (clk),
    .porta_rst  (porta_rst),
    .ctrl_enable(ctrl_enable),
    .ctrl_clear (ctrl_clear),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .rd_ptr     (rd_ptr),
    .bram_en    (bram_en),
    .bram_we    (bram_we),
    .bram_addr  (bram_addr),
    .bram_din   (bram_din),
    .wr_ptr     (wr_ptr),
    .frame_count(frame_count),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Reference model: everything derives from words written since reset/clear.
  int      m_state = M_IDLE;
  longint  m_words = 0;
  bit      m_ovf   = 1'b0;
  int      rdy_diff = 0;
  int      stray_we = 0;
  int      errs;

  logic [AW-1:0] exp_addr[$];
  logic [DW-1:0] exp_data[$];
  int            exp_cyc[$];
  logic [AW-1:0] obs_addr[$];
  logic [DW-1:0] obs_data[$];
  logic [3:0]    obs_we[$];
  int            obs_cyc[$];

  always @(negedge clk) begin
    if (bram_en === 1'b1) begin
      obs_addr.push_back(bram_addr);
      obs_data.push_back(bram_din);
      obs_we.push_back(bram_we);
      obs_cyc.push_back(cyc);
    end else if (bram_en === 1'b0 && bram_we !== 4'h0) begin
      stray_we++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock cycle: drive inputs, advance the model at the edge.
  task automatic step(input bit r, input bit e, input bit c, input bit v,
                      input logic [DW-1:0] d, input logic [PW-1:0] rd);
    int wr;
    int wif;
    bit full;
    bit rdy;
    bit xf;
    porta_rst   = r;
    ctrl_enable = e;
    ctrl_clear  = c;
    s_valid     = v;
    s_data      = d;
    rd_ptr      = rd;
    wr   = int'(m_words % DEPTH);
    full = (((wr + 1) % DEPTH) == int'(rd));
    rdy  = (m_state != M_IDLE) && !full;
    xf   = !r && v && rdy;
    #1;
    if (!r && s_ready !== rdy) rdy_diff++;
    @(posedge clk);
    if (r) begin
      m_state = M_IDLE;
      m_words = 0;
      m_ovf   = 1'b0;
    end else begin
      wif = int'(m_words % FW);
      if (m_state != M_IDLE && v && full) m_ovf = 1'b1;
      if (c && m_state == M_IDLE) begin
        m_words = 0;
        m_ovf   = 1'b0;
      end
      if (xf) begin
        exp_addr.push_back(AW'(wr * 4));
        exp_data.push_back(d);
        exp_cyc.push_back(cyc);
        m_words++;
      end
      case (m_state)
        M_IDLE:  if (e) m_state = M_RUN;
        M_RUN:   if (!e) m_state = (wif != 0) ? M_DRAIN : M_IDLE;
        default: begin
          if (e) m_state = M_RUN;
          else if (xf && wif == FW - 1) m_state = M_IDLE;
        end
      endcase
    end
    @(negedge clk);
    #2;
  endtask

  task automatic start_fresh();
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    exp_addr.delete(); exp_data.delete(); exp_cyc.delete();
    obs_addr.delete(); obs_data.delete(); obs_we.delete(); obs_cyc.delete();
    rdy_diff = 0;
    stray_we = 0;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b0, 1'b1, $urandom, '0);
    step(1'b1, 1'b1, 1'b0, 1'b1, $urandom, '0);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", s_ready); end
    total++; if (wr_ptr !== '0) begin bad++; $display("FAIL rst_wr_ptr: got %0d want 0", wr_ptr); end
    total++; if (frame_count !== '0) begin bad++; $display("FAIL rst_frames: got %0d want 0", frame_count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b want 0", overflow); end
    total++; if (bram_en !== 1'b0 || bram_we !== 4'h0) begin bad++; $display("FAIL rst_strobe: got en=%b we=%h want 0/0", bram_en, bram_we); end
    total++; if (bram_addr !== '0 || bram_din !== '0) begin bad++; $display("FAIL rst_port: got addr=%h din=%h want 0/0", bram_addr, bram_din); end
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_basic();
    start_fresh();
    step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 32'h100 + i, '0);
    total++; if (wr_ptr !== 14'd32) begin bad++; $display("FAIL basic_wr_ptr: got %0d want 32", wr_ptr); end
    total++; if (frame_count !== 32'd1) begin bad++; $display("FAIL basic_frames: got %0d want 1", frame_count); end
    total++; if (obs_addr.size() != 32 || obs_addr[0] !== 16'h0000 || obs_addr[31] !== 16'h007C)
      begin bad++; $display("FAIL basic_ends: got %0d writes, want 32 from 0x0000 to 0x007C", obs_addr.size()); end
    total++; errs = 0;
    if (obs_addr.size() != exp_addr.size()) errs++;
    else foreach (exp_addr[i]) if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i] || obs_we[i] !== 4'hF || obs_cyc[i] != exp_cyc[i] + 1) errs++;
    if (errs != 0) begin bad++; $display("FAIL basic_writes: got %0d writes (%0d bad), want %0d", obs_addr.size(), errs, exp_addr.size()); end
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_stop: got busy=%b want 0", busy); end
    total++; if (rdy_diff != 0) begin bad++; $display("FAIL basic_ready: got %0d ready errors want 0", rdy_diff); end
  endtask

  task automatic test_drain();
    start_fresh();
    step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b1, $urandom, '0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL drain_busy: got %b want 1", busy); end
    for (int k = 0; k < 400 && m_words < 32; k++) step(1'b0, 1'b0, 1'b0, 1'($urandom % 2), $urandom, '0);
    total++; if (wr_ptr !== 14'd32) begin bad++; $display("FAIL drain_wr_ptr: got %0d want 32", wr_ptr); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL drain_idle: got busy=%b want 0", busy); end
    total++; if (frame_count !== 32'd1) begin bad++; $display("FAIL drain_frames: got %0d want 1", frame_count); end
    s_valid = 1'b1; #1;
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL drain_ready: got %b want 0", s_ready); end
    s_valid = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b1, $urandom, '0);
    total++; errs = 0;
    if (obs_addr.size() != exp_addr.size()) errs++;
    else foreach (exp_addr[i]) if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i] || obs_we[i] !== 4'hF || obs_cyc[i] != exp_cyc[i] + 1) errs++;
    if (errs != 0) begin bad++; $display("FAIL drain_writes: got %0d writes (%0d bad), want %0d", obs_addr.size(), errs, exp_addr.size()); end
    total++; if (rdy_diff != 0) begin bad++; $display("FAIL drain_ready_seq: got %0d ready errors want 0", rdy_diff); end
  endtask

  task automatic test_full();
    logic [DW-1:0] da;
    logic [DW-1:0] db;
    int n;
    start_fresh();
    step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 1'b1, 1'b0, 1'b1, $urandom, '0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1, $urandom, '0);
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %b want 0", s_ready); end
    total++; if (wr_ptr !== 14'd16383) begin bad++; $display("FAIL full_wr_ptr: got %0d want 16383", wr_ptr); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL full_ovf: got %b want 1", overflow); end
    da = $urandom;
    db = $urandom;
    step(1'b0, 1'b1, 1'b0, 1'b1, da, 14'd16);
    step(1'b0, 1'b1, 1'b0, 1'b1, db, 14'd16);
    n = obs_addr.size();
    total++; if (n < 2 || obs_addr[n-2] !== 16'hFFFC || obs_addr[n-1] !== 16'h0000 || obs_data[n-2] !== da || obs_data[n-1] !== db)
      begin bad++; $display("FAIL full_wrap: got %0d writes, want last two at 0xFFFC then 0x0000", n); end
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0, 1'b1, $urandom, 14'd16);
    total++; if (wr_ptr !== 14'd15 || s_ready !== 1'b0) begin bad++; $display("FAIL full_again: got wr_ptr=%0d ready=%b want 15/0", wr_ptr, s_ready); end
    total++; if (frame_count !== 32'(m_words / FW)) begin bad++; $display("FAIL full_frames: got %0d want %0d", frame_count, m_words / FW); end
    total++; errs = 0;
    if (obs_addr.size() != exp_addr.size()) errs++;
    else foreach (exp_addr[i]) if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i] || obs_we[i] !== 4'hF || obs_cyc[i] != exp_cyc[i] + 1) errs++;
    if (errs != 0) begin bad++; $display("FAIL full_writes: got %0d writes (%0d bad), want %0d", obs_addr.size(), errs, exp_addr.size()); end
    total++; if (rdy_diff != 0) begin bad++; $display("FAIL full_ready_seq: got %0d ready errors want 0", rdy_diff); end
  endtask

  task automatic test_clear();
    start_fresh();
    step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 160; i++) step(1'b0, 1'b1, 1'b0, 1'b1, $urandom, '0);
    step(1'b0, 1'b1, 1'b0, 1'b1, $urandom, 14'd161);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 14'd161);
    total++; if (busy !== 1'b0 || frame_count !== 32'd5 || overflow !== 1'b1)
      begin bad++; $display("FAIL clear_pre: got busy=%b frames=%0d ovf=%b want 0/5/1", busy, frame_count, overflow); end
    step(1'b0, 1'b0, 1'b1, 1'b0, '0, 14'd161);
    total++; if (wr_ptr !== '0 || frame_count !== '0 || overflow !== 1'b0)
      begin bad++; $display("FAIL clear_idle: got wr_ptr=%0d frames=%0d ovf=%b want 0/0/0", wr_ptr, frame_count, overflow); end
    step(1'b0, 1'b1, 1'b0, 1'b0, '0, 14'd161);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1, $urandom, 14'd161);
    step(1'b0, 1'b1, 1'b0, 1'b1, $urandom, 14'd4);
    step(1'b0, 1'b1, 1'b1, 1'b0, '0, 14'd4);
    total++; if (wr_ptr !== 14'd3 || overflow !== 1'b1 || busy !== 1'b1)
      begin bad++; $display("FAIL clear_run: got wr_ptr=%0d ovf=%b busy=%b want 3/1/1", wr_ptr, overflow, busy); end
    total++; errs = 0;
    if (obs_addr.size() != exp_addr.size()) errs++;
    else foreach (exp_addr[i]) if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i] || obs_we[i] !== 4'hF || obs_cyc[i] != exp_cyc[i] + 1) errs++;
    if (errs != 0) begin bad++; $display("FAIL clear_writes: got %0d writes (%0d bad), want %0d", obs_addr.size(), errs, exp_addr.size()); end
  endtask

  task automatic test_reset_mid();
    start_fresh();
    step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 1'b1, $urandom, '0);
    step(1'b1, 1'b1, 1'b0, 1'b1, $urandom, '0);
    total++; if (bram_en !== 1'b0 || bram_we !== 4'h0) begin bad++; $display("FAIL midrst_strobe: got en=%b we=%h want 0/0", bram_en, bram_we); end
    total++; if (wr_ptr !== '0 || frame_count !== '0 || busy !== 1'b0)
      begin bad++; $display("FAIL midrst_state: got wr_ptr=%0d frames=%0d busy=%b want 0/0/0", wr_ptr, frame_count, busy); end
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    total++; errs = 0;
    if (obs_addr.size() != exp_addr.size()) errs++;
    else foreach (exp_addr[i]) if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i] || obs_we[i] !== 4'hF || obs_cyc[i] != exp_cyc[i] + 1) errs++;
    if (errs != 0) begin bad++; $display("FAIL midrst_writes: got %0d writes (%0d bad), want %0d", obs_addr.size(), errs, exp_addr.size()); end
  endtask

  task automatic test_random_gaps();
    start_fresh();
    step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 6000 && m_words < 1000; k++) step(1'b0, 1'b1, 1'b0, 1'($urandom % 2), $urandom, '0);
    step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    total++; if (wr_ptr !== 14'd1000) begin bad++; $display("FAIL rand_wr_ptr: got %0d want 1000", wr_ptr); end
    total++; if (frame_count !== 32'd31) begin bad++; $display("FAIL rand_frames: got %0d want 31", frame_count); end
    total++; errs = 0;
    if (obs_addr.size() != 1000 || obs_addr.size() != exp_addr.size()) errs++;
    else foreach (exp_addr[i]) if (obs_addr[i] !== AW'(i * 4) || obs_data[i] !== exp_data[i] || obs_we[i] !== 4'hF || obs_cyc[i] != exp_cyc[i] + 1) errs++;
    if (errs != 0) begin bad++; $display("FAIL rand_writes: got %0d writes (%0d bad), want %0d", obs_addr.size(), errs, exp_addr.size()); end
    total++; if (stray_we != 0) begin bad++; $display("FAIL rand_stray_we: got %0d strobes without enable want 0", stray_we); end
    total++; if (rdy_diff != 0) begin bad++; $display("FAIL rand_ready_seq: got %0d ready errors want 0", rdy_diff); end
  endtask

  initial begin
    porta_rst   = 1'b1;
    ctrl_enable = 1'b0;
    ctrl_clear  = 1'b0;
    s_valid     = 1'b0;
    s_data      = '0;
    rd_ptr      = '0;
    @(negedge clk);
    #2;
    test_reset();
    test_basic();
    test_drain();
    test_full();
    test_clear();
    test_reset_mid();
    test_random_gaps();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bram_ring_writer.md
BRAM_RING_WRITER -- requirements
Module: bram_ring_writer

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 16, meaning BRAM byte-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning BRAM word width.
REQ-003 The block SHALL have parameter DEPTH, default 16384, meaning ring size in words, a power of two; PW = log2(DEPTH).
REQ-004 The block SHALL have parameter FRAME_WORDS, default 32, meaning words per frame, a power of two that divides DEPTH.
REQ-005 The block SHALL have a single clock and a synchronous, active-high reset.
REQ-006 porta_clk  in  1  is the single clock; all logic is on its rising edge.
REQ-007 porta_rst  in  1  is the synchronous, active-high reset.
REQ-008 ctrl_enable  in  1  is the run request level from software.
REQ-009 ctrl_clear  in  1  is a one-cycle pulse that zeroes the pointers and status; it is honoured only in IDLE.
REQ-010 s_valid  in  1  marks source data as valid.
REQ-011 s_data  in  DATA_WIDTH  is the source word.
REQ-012 s_ready  out  1  accepts the source word; a transfer occurs when s_valid and s_ready are both high.
REQ-013 rd_ptr  in  PW  is the software read pointer, in words, quasi-static.
REQ-014 bram_en  out  1  drives the BRAM port-A enable.
REQ-015 bram_we  out  4  drives the BRAM port-A byte write enables.
REQ-016 bram_addr  out  ADDR_WIDTH  drives the BRAM port-A byte address.
REQ-017 bram_din  out  DATA_WIDTH  drives the BRAM port-A write data.
REQ-018 wr_ptr  out  PW  is the next word index to be written.
REQ-019 frame_count  out  32  is the number of completed frames.
REQ-020 overflow  out  1  is a sticky flag indicating the source was stalled by a full ring.
REQ-021 busy  out  1  is high when the state is not IDLE.

Function
REQ-022 The FSM SHALL have three states: IDLE, RUN and DRAIN.
- IDLE->RUN when ctrl_enable=1.
- RUN->DRAIN when ctrl_enable=0 and word_in_frame!=0.
- RUN->IDLE when ctrl_enable=0 and word_in_frame==0.
- DRAIN->IDLE when the last word of the current frame transfers.
- DRAIN->RUN when ctrl_enable returns to 1.
REQ-023 full SHALL equal ((wr_ptr+1) mod DEPTH == rd_ptr), so one slot is always left unused.
REQ-024 s_ready SHALL equal (state != IDLE) and !full, combinationally.
REQ-025 On each transfer, at the next edge:
- bram_en=1, bram_we=4'hF;
- bram_addr = {wr_ptr, 2'b00}, zero-extended to ADDR_WIDTH;
- bram_din = s_data;
- wr_ptr increments mod DEPTH.
REQ-026 Write latency SHALL be exactly 1 cycle from transfer to the registered BRAM strobe; with no transfer, bram_en=0 and bram_we=0 for that cycle.
REQ-027 bram_addr and bram_din SHALL hold their last value while bram_en=0.
REQ-028 word_in_frame SHALL be an internal counter of width log2(FRAME_WORDS) that increments on each transfer and wraps to 0.
REQ-029 frame_count SHALL increment by 1 in the same edge as the transfer that wraps word_in_frame, and SHALL itself wrap 2^32-1 -> 0.
REQ-030 wr_ptr SHALL wrap DEPTH-1 -> 0, and the write to address {DEPTH-1, 2'b00} SHALL be followed by a write to address 0.
REQ-031 overflow SHALL be set on any cycle with state != IDLE, s_valid=1 and full=1; it SHALL stay set until reset or an honoured ctrl_clear.
REQ-032 ctrl_clear in IDLE SHALL zero wr_ptr, word_in_frame, frame_count and overflow at the next edge; ctrl_clear in RUN or DRAIN SHALL be ignored.
REQ-033 If rd_ptr changes in the same cycle as a transfer, full SHALL use the current-cycle rd_ptr; no write SHALL ever land at word index rd_ptr-1 (mod DEPTH) under the rule of REQ-023.
REQ-034 In DRAIN, words SHALL be accepted only until the frame completes; s_ready SHALL be 0 in the cycle after the last word of the frame transfers.

Reset
REQ-035 While porta_rst=1 at an edge, the next state SHALL be:
- state=IDLE;
- wr_ptr=0, word_in_frame=0, frame_count=0;
- overflow=0, bram_en=0, bram_we=0;
- bram_addr=0, bram_din=0;
- busy=0, and therefore s_ready=0.
REQ-036 Reset asserted mid-frame or mid-write SHALL abandon the frame; no BRAM write strobe SHALL occur in the cycle after a reset edge.

Verification
REQ-037 Basic write: reset, then ctrl_enable=1, rd_ptr=0, and 32 back-to-back words 0x100..0x11F -> bram_addr 0x0000..0x007C with a 1-cycle lag, frame_count=1, wr_ptr=32.
REQ-038 Stop mid-frame: ctrl_enable drops after 10 words -> state DRAIN, busy=1; 22 more words accepted, then IDLE with frame_count=1 and s_ready=0.
REQ-039 Full: rd_ptr=0, write 16383 words -> s_ready=0 at wr_ptr=16383 with overflow=1 while s_valid is held; set rd_ptr=16 -> the next write goes to byte address 0xFFFC, then to address 0x0000 (wrap).
REQ-040 Clear: in IDLE with overflow=1 and frame_count=5, pulse ctrl_clear -> all status zero the next cycle; the same pulse in RUN -> no change.
REQ-041 Reset mid-stream: porta_rst asserted at word 7 of a frame -> bram_en=0 the next cycle, wr_ptr=0, frame_count unchanged from 0, state IDLE.
REQ-042 Random s_valid gaps at 50% over 1000 words -> every accepted word appears exactly once, in order, at consecutive word addresses, as checked by a scoreboard.
